// File: rtl/ctrl_data_arbiter.sv
// Round-robin arbiter sharing one ctrl_data_fifo write side among NUM_REQ producers, with per-producer burst lock.
// Latency: one cycle, from an accepted beat to fifo_data_valid/fifo_ctrl_valid.
// Backpressure: the beat is held while either FIFO ready is low; req_ready stays low until that beat is pushed.
//
// Ports:
//   clk, rst_n                          clock and asynchronous active-low reset
//   req_valid/req_ready/req_last        per-requester handshake and end-of-burst marker
//   req_data/req_ctrl                   packed beats, requester i at [i*W +: W]
//   fifo_din_data/fifo_data_valid/fifo_data_ready   FIFO data write side
//   fifo_ctrl_data/fifo_ctrl_valid/fifo_ctrl_ready  FIFO ctrl write side
//   grant_id, locked, burst_trunc       status of the held beat and the arbiter
// Optional macro CTRL_DATA_ARB_STATS_EN adds stats_clr and the grant_count per-requester counters.
module ctrl_data_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 32,
  parameter int MAX_BURST  = 16,
  localparam int ID_W      = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ-1:0]             req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0]  req_ctrl,
  output logic [DATA_WIDTH-1:0]          fifo_din_data,
  output logic                           fifo_data_valid,
  input  logic                           fifo_data_ready,
  output logic [CTRL_WIDTH-1:0]          fifo_ctrl_data,
  output logic                           fifo_ctrl_valid,
  input  logic                           fifo_ctrl_ready,
  output logic [ID_W-1:0]                grant_id,
  output logic                           locked,
  output logic                           burst_trunc
`ifdef CTRL_DATA_ARB_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [NUM_REQ*16-1:0]          grant_count
`endif
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                state, state_nxt;
  logic [ID_W-1:0]       rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]       owner, owner_nxt;
  logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
  logic                  trunc_nxt;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [CTRL_WIDTH-1:0] out_ctrl;
  logic [ID_W-1:0]       out_id;

  logic                  push, slot_free;
  logic                  win_vld, win_last, accept;
  logic [ID_W-1:0]       win_id;
  logic [ID_W-1:0]       idx;

  function automatic logic [ID_W-1:0] inc_wrap(input logic [ID_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + ID_W'(1);
  endfunction

  assign push      = out_valid && fifo_data_ready && fifo_ctrl_ready;
  assign slot_free = !out_valid || push;

  // Winner: the lock owner while LOCKED, otherwise the first valid requester at
  // or after rr_ptr. Walking the offsets downward lets the smallest offset win.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    if (state == LOCKED) begin
      win_vld = req_valid[owner];
      win_id  = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (req_valid[idx]) begin
          win_vld = 1'b1;
          win_id  = idx;
        end
      end
    end
  end

  assign accept   = win_vld && slot_free && rst_n;
  assign win_last = req_last[win_id];

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    beat_cnt_nxt = beat_cnt;
    trunc_nxt    = 1'b0;
    if (accept) begin
      if (state == IDLE) begin
        if (win_last) begin
          rr_ptr_nxt = inc_wrap(win_id);
        end else if (MAX_BURST == 1) begin
          // A single-beat limit releases every beat; a non-last one is a truncation.
          rr_ptr_nxt = inc_wrap(win_id);
          trunc_nxt  = 1'b1;
        end else begin
          state_nxt    = LOCKED;
          owner_nxt    = win_id;
          beat_cnt_nxt = CNT_W'(1);
        end
      end else begin
        if (win_last) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = inc_wrap(owner);
        end else if (beat_cnt + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = inc_wrap(owner);
          trunc_nxt  = 1'b1;
        end else begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      beat_cnt    <= '0;
      burst_trunc <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      owner       <= owner_nxt;
      beat_cnt    <= beat_cnt_nxt;
      burst_trunc <= trunc_nxt;
    end
  end

  // Single output register feeds both FIFO sides so data and ctrl never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ctrl  <= '0;
      out_id    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= req_data[int'(win_id) * DATA_WIDTH +: DATA_WIDTH];
      out_ctrl  <= req_ctrl[int'(win_id) * CTRL_WIDTH +: CTRL_WIDTH];
      out_id    <= win_id;
    end else if (push) begin
      out_valid <= 1'b0;
    end
  end

  assign fifo_data_valid = out_valid;
  assign fifo_ctrl_valid = out_valid;
  assign fifo_din_data   = out_data;
  assign fifo_ctrl_data  = out_ctrl;
  assign grant_id        = out_id;
  assign locked          = (state == LOCKED);

`ifdef CTRL_DATA_ARB_STATS_EN
  logic [15:0] cnt [NUM_REQ];

  // Clear wins over a same-cycle increment; counts stick at 0xFFFF.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (stats_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (accept && cnt[win_id] != 16'hFFFF) begin
      cnt[win_id] <= cnt[win_id] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_count[g*16 +: 16] = cnt[g];
  end
`endif

endmodule

// File: doc/ctrl_data_arbiter.md
# ctrl_data_arbiter

Round-robin arbiter that shares one `ctrl_data_fifo` write side between `NUM_REQ` producers. Each producer offers ctrl+data beats with valid/ready and may lock the arbiter for a multi-beat burst. The block registers the winning beat and drives the FIFO's `din_data`/`data_valid` and `ctrl_data`/`ctrl_valid` pair together, so the two internal FIFOs never skew. It sits directly in front of the FIFO, in place of a single producer.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16
- `DATA_WIDTH`, 32: data beat width
- `CTRL_WIDTH`, 32: ctrl word width
- `MAX_BURST`, 16: maximum beats per locked burst, ≥1
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous and active-low
- `req_valid` in NUM_REQ: per-requester beat valid
- `req_ready` out NUM_REQ: per-requester beat accepted
- `req_last` in NUM_REQ: beat ends the requester's burst
- `req_data` in NUM_REQ*DATA_WIDTH: packed data; requester i is at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ctrl` in NUM_REQ*CTRL_WIDTH: packed ctrl, same packing
- `fifo_din_data` out DATA_WIDTH: to FIFO `din_data`
- `fifo_data_valid` out 1: to FIFO `data_valid`
- `fifo_data_ready` in 1: from FIFO `data_ready`
- `fifo_ctrl_data` out CTRL_WIDTH: to FIFO `ctrl_data`
- `fifo_ctrl_valid` out 1: to FIFO `ctrl_valid`
- `fifo_ctrl_ready` in 1: from FIFO `ctrl_ready`
- `grant_id` out $clog2(NUM_REQ): index of the requester of the beat currently in the output register
- `locked` out 1: a burst is in progress
- `burst_trunc` out 1: one-cycle pulse when a burst is force-released

## Operation
- **Output register.** Holds one beat: `out_valid`, data, ctrl, id.
  - `fifo_data_valid` = `fifo_ctrl_valid` = `out_valid`.
  - `push` = `out_valid && fifo_data_ready && fifo_ctrl_ready`.
  - `slot_free` = `!out_valid || push`.
- **Winner selection, IDLE.** First index at or after `rr_ptr`, searching upward with wrap, whose `req_valid` is high.
- **Winner selection, LOCKED.** `owner` only, and only if `req_valid[owner]` is high.
- **Handshake.** `req_ready[i]` = (i == winner) && `slot_free` && `rst_n`. At most one bit is high.
- **Accept.** `req_valid[i] && req_ready[i]` loads the output register with requester i's data, ctrl and id.
- **FSM IDLE.**
  - Accept with `req_last`=1: stay IDLE; `rr_ptr` ← (winner+1) mod NUM_REQ.
  - Accept with `req_last`=0: go LOCKED; `owner` ← winner; `beat_cnt` ← 1.
- **FSM LOCKED.**
  - Accept with `req_last`=1: go IDLE; `rr_ptr` ← (owner+1) mod NUM_REQ.
  - Accept with `req_last`=0 and `beat_cnt`+1 == MAX_BURST: go IDLE; `rr_ptr` ← owner+1; pulse `burst_trunc` the next cycle.
  - Any other accept: `beat_cnt`++.
  - No accept: hold state; other requesters stay blocked even if the owner deasserts valid.
- **Counter width.** `beat_cnt` width is $clog2(MAX_BURST+1).
- **MAX_BURST=1.** Every beat releases the lock; `burst_trunc` pulses whenever `req_last`=0.
- **Reset behaviour.** Reset mid-burst discards the held beat and the lock. The FIFO must be reset with the same `rst_n`.

## Timing
- **Reset values.** `out_valid`=0, `fifo_*_valid`=0, `fifo_din_data`=0, `fifo_ctrl_data`=0, `grant_id`=0, `locked`=0, `burst_trunc`=0, `req_ready`=0, `rr_ptr`=0, state IDLE.
- **Latency.** Accept on edge N → `fifo_*_valid` high from edge N onward, i.e. visible in cycle N+1.
- **Throughput.** One beat per cycle while the FIFO is ready.
- **Backpressure.** With either FIFO ready low, the held beat is stable. `req_ready` stays low until a push.
- **Combinational path.** `req_ready` depends combinationally on `req_valid` and the FIFO readies. There is no combinational path from `req_*` to `fifo_*`.
- **Status timing.** `locked` is registered; it is high in the cycle after a non-last accept in IDLE.

## Configuration
- **`CTRL_DATA_ARB_STATS_EN` defined.**
  - Adds input `stats_clr` (1 bit).
  - Adds output `grant_count` (NUM_REQ*16 bits): per-requester saturating count of accepted beats.
  - Counts reset to 0. `stats_clr` zeroes all counts synchronously and takes priority over an increment in the same cycle.
  - Counts saturate at 0xFFFF.
- **Undefined.** The two ports and the counters are absent. Arbitration behaviour is identical.

## Test plan
- **Basic round robin.** NUM_REQ=4, all `req_valid`=1, all `req_last`=1, FIFO always ready → grants 0,1,2,3,0,… one beat per cycle. `fifo_ctrl_data`/`fifo_din_data` match each source.
- **Locked burst.** Req1 sends 3 beats (last on beat 3) while req0 and req2 are valid → 3 consecutive req1 beats, `locked`=1 during the burst, then req2 is granted (rr_ptr=2).
- **Burst truncation.** MAX_BURST=4; req0 sends 6 beats with `req_last`=0 → lock released after beat 4, `burst_trunc` pulses once, req1 is granted next.
- **Backpressure.** `fifo_ctrl_ready`=0 for 5 cycles with `out_valid`=1 → outputs stable, all `req_ready`=0, no beat lost or duplicated after release. The same holds with only `fifo_data_ready` low.
- **Reset mid-burst.** Assert `rst_n`=0 after beat 2 of a 5-beat burst → all outputs at reset values immediately. After release, req0 wins first.
- **Stats.** With `CTRL_DATA_ARB_STATS_EN`: 10 beats from req3 → `grant_count[3]`=10. Asserting `stats_clr` together with an accept → 0.
